// File: rtl/peres_mac_unit.sv
// peres_mac_unit: sequential multiply-accumulate stage for the matrix multiplier.
// It takes N operand pairs over a valid/ready handshake and forms each product
// with a WIDTH-cycle shift-add multiplier. It adds the products into an
// accumulator and presents the dot product over a second valid/ready handshake.
// Every addition goes through a ripple-carry adder made of Peres reversible
// gates.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operand pair present
//   in_ready   out  1      block can accept a pair (high only in IDLE)
//   a_in       in   WIDTH  row element (multiplicand)
//   b_in       in   WIDTH  column element (multiplier)
//   out_valid  out  1      result is valid (high only in DONE)
//   out_ready  in   1      downstream accepts the result
//   result     out  ACC_W  dot product; reads 0 whenever out_valid is 0
//   busy       out  1      high in any state other than IDLE

// Peres gate: P = A, Q = A ^ B, R = (A & B) ^ C.
// Ports:
//   a_i, b_i, c_i  in   1  gate inputs
//   p_o, q_o, r_o  out  1  gate outputs
module peres_gate (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic p_o,
  output logic q_o,
  output logic r_o
);
  assign p_o = a_i;
  assign q_o = a_i ^ b_i;
  assign r_o = (a_i & b_i) ^ c_i;
endmodule

// W-bit ripple-carry adder. Each bit is a full adder made of two Peres gates.
// The first gate, (a, b, 0), yields the propagate term g = a^b and the
// generate term h = a&b. The second gate, (g, cin, h), yields
// sum = g^cin and cout = (g&cin)^h.
// Ports:
//   a_i, b_i  in   W  addends
//   sum_o     out  W  sum modulo 2^W
//   cout_o    out  1  carry out of the top bit
module peres_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);
  logic [W:0]   carry;
  logic [W-1:0] g;
  logic [W-1:0] h;
  // The P output of a Peres gate only passes input A through, so nothing uses it.
  logic [W-1:0] p1_unused;
  logic [W-1:0] p2_unused;

  assign carry[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_bit
      peres_gate u_half (
        .a_i(a_i[gi]),
        .b_i(b_i[gi]),
        .c_i(1'b0),
        .p_o(p1_unused[gi]),
        .q_o(g[gi]),
        .r_o(h[gi])
      );
      peres_gate u_full (
        .a_i(g[gi]),
        .b_i(carry[gi]),
        .c_i(h[gi]),
        .p_o(p2_unused[gi]),
        .q_o(sum_o[gi]),
        .r_o(carry[gi+1])
      );
    end
  endgenerate

  assign cout_o = carry[W];
endmodule

module peres_mac_unit #(
  parameter  int WIDTH = 8,
  parameter  int N     = 4,
  // Wide enough for N*(2^WIDTH-1)^2, with at least one guard bit.
  localparam int ACC_W = 2*WIDTH + (($clog2(N) < 1) ? 1 : $clog2(N))
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] result,
  output logic             busy
);
  localparam int PW     = 2*WIDTH;
  localparam int BCNT_W = $clog2(WIDTH + 1);
  localparam int PCNT_W = (($clog2(N + 1) < 1) ? 1 : $clog2(N + 1));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e             state_q,   state_d;
  logic [PW-1:0]      mcand_q,   mcand_d;
  logic [WIDTH-1:0]   mplier_q,  mplier_d;
  logic [PW-1:0]      prod_q,    prod_d;
  logic [BCNT_W-1:0]  bitcnt_q,  bitcnt_d;
  logic [ACC_W-1:0]   acc_q,     acc_d;
  logic [PCNT_W-1:0]  paircnt_q, paircnt_d;
  logic [ACC_W-1:0]   result_q,  result_d;

  logic [PW-1:0]      prod_sum;
  logic [ACC_W-1:0]   acc_sum;
  // Neither adder can carry out. The product fits in 2*WIDTH bits and the
  // accumulator is sized for the full dot product.
  logic               prod_cout_unused;
  logic               acc_cout_unused;

  peres_adder #(.W(PW)) u_prod_add (
    .a_i   (prod_q),
    .b_i   (mcand_q),
    .sum_o (prod_sum),
    .cout_o(prod_cout_unused)
  );

  peres_adder #(.W(ACC_W)) u_acc_add (
    .a_i   (acc_q),
    .b_i   ({{(ACC_W-PW){1'b0}}, prod_q}),
    .sum_o (acc_sum),
    .cout_o(acc_cout_unused)
  );

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    prod_d    = prod_q;
    bitcnt_d  = bitcnt_q;
    acc_d     = acc_q;
    paircnt_d = paircnt_q;
    result_d  = result_q;

    case (state_q)
      IDLE: begin
        // in_ready is high throughout IDLE, so in_valid alone marks the accept edge.
        if (in_valid) begin
          state_d  = MUL;
          mcand_d  = {{WIDTH{1'b0}}, a_in};
          mplier_d = b_in;
          prod_d   = '0;
          bitcnt_d = '0;
        end
      end
      MUL: begin
        if (mplier_q[0]) begin
          prod_d = prod_sum;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        bitcnt_d = bitcnt_q + BCNT_W'(1);
        if (bitcnt_q == BCNT_W'(WIDTH - 1)) begin
          state_d = ACC;
        end
      end
      ACC: begin
        acc_d     = acc_sum;
        paircnt_d = paircnt_q + PCNT_W'(1);
        if (paircnt_q == PCNT_W'(N - 1)) begin
          state_d  = DONE;
          result_d = acc_sum;
        end else begin
          state_d = IDLE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d   = IDLE;
          acc_d     = '0;
          paircnt_d = '0;
          result_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      prod_q    <= '0;
      bitcnt_q  <= '0;
      acc_q     <= '0;
      paircnt_q <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      prod_q    <= prod_d;
      bitcnt_q  <= bitcnt_d;
      acc_q     <= acc_d;
      paircnt_q <= paircnt_d;
      result_q  <= result_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  // result_q is only non-zero while in DONE.
  assign result    = result_q;
endmodule
